sensor_ahb_wrapper: RTL and testbench

SENSOR_AHB_WRAPPER -- requirements
Module: sensor_ahb_wrapper

---
 rtl/sensor_ahb_wrapper.sv | 154 +++++++++++++++
 tb/tb_sensor_ahb_wrapper.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_ahb_wrapper.sv
// AHB slave for a set of sensor channels: wait-stated buffer reads,
// per-channel CTRL/STATUS/CLEAR registers and a combined interrupt.
module sensor_ahb_wrapper #(
    parameter int          NUM_CH    = 4,
    parameter int          READ_LAT  = 2,
    parameter logic [3:0]  MASTER_ID = 4'b0001,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 HSEL,
    input  logic [1:0]           HTRANS,
    input  logic [31:0]          HADDR,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [31:0]          HWDATA,
    input  logic [3:0]           HMASTER,
    input  logic                 HMASTLOCK,
    output logic [31:0]          HRDATA,
    output logic                 HREADY,
    output logic [1:0]           HRESP,
    input  logic [32*NUM_CH-1:0] sctrl_out,
    input  logic [NUM_CH-1:0]    sctrl_full,
    output logic [NUM_CH-1:0]    sctrl_en,
    output logic [NUM_CH-1:0]    sctrl_clear,
    output logic [5:0]           sctrl_addr,
    output logic                 irq
);
    typedef enum logic [2:0] {IDLE, RADDR, RWAIT, RRESP, REG, ERR1, ERR2} state_t;
    localparam logic [1:0] RG_BUF = 2'd0, RG_CTRL = 2'd1, RG_CLEAR = 2'd2, RG_STATUS = 2'd3;

    state_t            r_state, w_next;
    logic [11:0]       w_off;
    logic [1:0]        w_ch, w_rg;
    logic              w_hready, w_accept, w_err, w_reg_wr;
    logic [1:0]        r_ch, r_rg;
    logic [5:0]        r_word;
    logic              r_write;
    logic [2:0]        r_cnt;
    logic [NUM_CH-1:0] r_ch_en, r_irq_en, r_pend, r_full_q, r_clear;
    logic [NUM_CH-1:0] w_sel, w_pend_clr;
    logic [31:0]       w_buf_data, w_reg_data;
    logic              r_irq;
    logic              w_unused;

    // The window is 4 KB aligned, so only the low 12 bits carry the offset.
    assign w_off    = HADDR[11:0] - BASE_ADDR[11:0];
    assign w_ch     = w_off[11:10];
    assign w_rg     = w_off[9:8];
    assign w_hready = !(r_state inside {RADDR, RWAIT, ERR1});
    assign w_accept = HSEL && HTRANS[1] && w_hready;
    assign w_err    = (HMASTER != MASTER_ID) || (HSIZE != 3'b010) ||
                      (int'(w_ch) >= NUM_CH) || (HWRITE && w_rg == RG_BUF);
    assign w_reg_wr = (r_state == REG) && r_write;
    assign w_unused = ^{HMASTLOCK, HTRANS[0], HADDR[31:12], w_off[1:0], HWDATA[31:3]};

    always_comb begin
        w_sel      = '0;
        w_buf_data = '0;
        w_reg_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(r_ch) == c) begin
                w_sel[c]   = 1'b1;
                w_buf_data = sctrl_out[32*c +: 32];
                case (r_rg)
                    RG_CTRL:   w_reg_data = {30'b0, r_irq_en[c], r_ch_en[c]};
                    RG_STATUS: w_reg_data = {29'b0, r_pend[c], sctrl_full[c], r_ch_en[c]};
                    default:   w_reg_data = '0;
                endcase
            end
        end
    end

    assign w_pend_clr = (w_reg_wr && (r_rg == RG_CLEAR || (r_rg == RG_STATUS && HWDATA[2])))
                        ? w_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        HRESP      = 2'b00;
        HRDATA     = '0;
        sctrl_en   = '0;
        sctrl_addr = '0;
        case (r_state)
            RADDR: begin
                sctrl_en   = w_sel;
                sctrl_addr = r_word;
                w_next     = (READ_LAT == 1) ? RRESP : RWAIT;
            end
            RWAIT: begin
                sctrl_en   = w_sel;
                sctrl_addr = r_word;
                if (r_cnt <= 3'd1) w_next = RRESP;
            end
            RRESP: begin
                sctrl_en   = w_sel;
                sctrl_addr = r_word;
                HRDATA     = w_buf_data;
            end
            REG:     if (!r_write) HRDATA = w_reg_data;
            ERR1: begin
                HRESP  = 2'b01;
                w_next = ERR2;
            end
            ERR2:    HRESP = 2'b01;
            default: ;
        endcase
        // Every zero-wait state doubles as an address phase for the next transfer.
        if (w_hready)
            w_next = !w_accept ? IDLE : w_err ? ERR1 : (w_rg == RG_BUF) ? RADDR : REG;
    end

    assign HREADY      = w_hready;
    assign sctrl_clear = r_clear;
    assign irq         = r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch     <= '0;
            r_rg     <= '0;
            r_word   <= '0;
            r_write  <= 1'b0;
            r_cnt    <= '0;
            r_ch_en  <= '0;
            r_irq_en <= '0;
            r_pend   <= '0;
            r_full_q <= '0;
            r_clear  <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ch    <= w_ch;
                r_rg    <= w_rg;
                r_word  <= w_off[7:2];
                r_write <= HWRITE;
            end
            if (r_state == RADDR)                  r_cnt <= 3'(READ_LAT - 1);
            else if (r_state == RWAIT && r_cnt != 0) r_cnt <= r_cnt - 3'd1;
            if (w_reg_wr && r_rg == RG_CTRL) begin
                r_ch_en  <= (r_ch_en  & ~w_sel) | (w_sel & {NUM_CH{HWDATA[0]}});
                r_irq_en <= (r_irq_en & ~w_sel) | (w_sel & {NUM_CH{HWDATA[1]}});
            end
            r_clear  <= (w_reg_wr && r_rg == RG_CLEAR) ? w_sel : '0;
            r_full_q <= sctrl_full;
            // A new full edge outranks a clear landing on the same clock.
            r_pend   <= (r_pend & ~w_pend_clr) | (sctrl_full & ~r_full_q & r_irq_en);
            r_irq    <= |r_pend;
        end
    end
endmodule

// File: tb/tb_sensor_ahb_wrapper.sv
// Randomized bench for sensor_ahb_wrapper against a channel-level register model.
module tb_sensor_ahb_wrapper;
    localparam int          NUM_CH   = 4;
    localparam int          READ_LAT = 2;
    localparam logic [3:0]  MID      = 4'b0001;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [1:0]  BUF = 2'd0, CTRL = 2'd1, CLR = 2'd2, STAT = 2'd3;

    logic clk = 1'b0;
    logic rst;
    logic HSEL, HWRITE, HMASTLOCK, HREADY, irq;
    logic [1:0] HTRANS, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0] HSIZE;
    logic [3:0] HMASTER;
    logic [32*NUM_CH-1:0] sctrl_out;
    logic [NUM_CH-1:0] sctrl_full, sctrl_en, sctrl_clear;
    logic [5:0] sctrl_addr;

    always #5 clk = ~clk;

    sensor_ahb_wrapper #(.NUM_CH(NUM_CH), .READ_LAT(READ_LAT), .MASTER_ID(MID), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .sctrl_out(sctrl_out),
        .sctrl_full(sctrl_full), .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear),
        .sctrl_addr(sctrl_addr), .irq(irq));

    int n_chk = 0, n_err = 0;
    logic [31:0] m_out [NUM_CH];
    logic [NUM_CH-1:0] m_ch_en, m_irq_en, m_pend;
    int r_stall, r_en_cyc, r_onehot_bad;
    logic [31:0] r_data;
    logic [1:0] r_resp0, r_resp;
    logic [NUM_CH-1:0] r_en_or;
    logic [5:0] r_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called with the bus at a zero-wait point; returns in the last data-phase cycle.
    task automatic xfer(input logic [1:0] ch, input logic [1:0] rg, input logic [5:0] w,
                        input logic wr, input logic [31:0] wd, input logic [2:0] sz, input logic [3:0] mst);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | {20'h0, ch, rg, w, 2'b00};
        HWRITE = wr; HSIZE = sz; HMASTER = mst;
        tick(1);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
        r_stall = 0; r_en_cyc = 0; r_en_or = '0; r_onehot_bad = 0;
        r_resp0 = HRESP; r_addr = sctrl_addr;
        for (int i = 0; i < 16; i++) begin
            if (sctrl_en != '0) r_en_cyc++;
            r_en_or |= sctrl_en;
            if (!$onehot0(sctrl_en)) r_onehot_bad++;
            if (HREADY) break;
            r_stall++;
            tick(1);
        end
        r_data = HRDATA; r_resp = HRESP;
    endtask

    function automatic logic [31:0] exp_reg(input logic [1:0] ch, input logic [1:0] rg);
        case (rg)
            CTRL:    return {30'b0, m_irq_en[ch], m_ch_en[ch]};
            STAT:    return {29'b0, m_pend[ch], sctrl_full[ch], m_ch_en[ch]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic new_out();
        for (int c = 0; c < NUM_CH; c++) begin
            m_out[c] = $urandom;
            sctrl_out[32*c +: 32] = m_out[c];
        end
    endtask

    task automatic rd_buf(input logic [1:0] ch, input logic [5:0] w);
        xfer(ch, BUF, w, 1'b0, 32'h0, 3'b010, MID);
        chk("buf_data", r_data, m_out[ch]);
        chk("buf_resp", 32'(r_resp), 32'h0);
        chk("buf_stall", 32'(r_stall), 32'(READ_LAT));
        chk("buf_en", 32'(r_en_or), 32'(1) << ch);
        chk("buf_en_cycles", 32'(r_en_cyc), 32'(READ_LAT + 1));
        chk("buf_addr", 32'(r_addr), 32'(w));
        chk("buf_onehot", 32'(r_onehot_bad), 32'h0);
    endtask

    task automatic reg_ok(input string tag);
        chk({tag, "_stall"}, 32'(r_stall), 32'h0);
        chk({tag, "_resp"}, 32'(r_resp), 32'h0);
        chk({tag, "_en"}, 32'(r_en_or), 32'h0);
    endtask

    task automatic rd_reg(input logic [1:0] ch, input logic [1:0] rg);
        xfer(ch, rg, 6'($urandom), 1'b0, 32'h0, 3'b010, MID);
        chk("reg_rdata", r_data, exp_reg(ch, rg));
        reg_ok("reg_rd");
    endtask

    task automatic wr_reg(input logic [1:0] ch, input logic [1:0] rg, input logic [31:0] d);
        xfer(ch, rg, 6'($urandom), 1'b1, d, 3'b010, MID);
        reg_ok("reg_wr");
        case (rg)
            CTRL: begin m_ch_en[ch] = d[0]; m_irq_en[ch] = d[1]; end
            STAT: if (d[2]) m_pend[ch] = 1'b0;
            CLR:  m_pend[ch] = 1'b0;
            default: ;
        endcase
    endtask

    task automatic err_xfer(input logic [1:0] ch, input logic [1:0] rg, input logic wr,
                            input logic [2:0] sz, input logic [3:0] mst);
        xfer(ch, rg, 6'($urandom), wr, $urandom, sz, mst);
        chk("err_stall", 32'(r_stall), 32'h1);
        chk("err_resp1", 32'(r_resp0), 32'h1);
        chk("err_resp2", 32'(r_resp), 32'h1);
        chk("err_en", 32'(r_en_or), 32'h0);
    endtask

    // Takes effect at the next clock edge.
    task automatic set_full(input int c, input logic v);
        if (v && !sctrl_full[c] && m_irq_en[c]) m_pend[c] = 1'b1;
        sctrl_full[c] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] ch;
        logic [3:0] mst;
        logic [2:0] sz;
        int op, c;
        rst = 1'b1; HSEL = 0; HTRANS = 0; HADDR = 0; HWRITE = 0; HSIZE = 0; HWDATA = 0;
        HMASTER = 0; HMASTLOCK = 0; sctrl_out = '0; sctrl_full = '0;
        m_ch_en = '0; m_irq_en = '0; m_pend = '0;
        for (int i = 0; i < NUM_CH; i++) m_out[i] = 32'h0;
        tick(2);
        rst = 1'b0;
        chk("rst_hready", 32'(HREADY), 32'h1);
        chk("rst_hresp", 32'(HRESP), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_en", 32'(sctrl_en), 32'h0);
        chk("rst_clear", 32'(sctrl_clear), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        // buffer read ch1 word 5
        new_out();
        m_out[1] = 32'hA5A5_0001; sctrl_out[63:32] = 32'hA5A5_0001;
        rd_buf(2'd1, 6'd5);
        chk("req_buf_data", r_data, 32'hA5A5_0001);

        // CTRL, pend, irq, W1C
        wr_reg(2'd0, CTRL, 32'h3);
        tick(1);
        set_full(0, 1'b1);
        tick(2);
        chk("irq_set", 32'(irq), 32'h1);
        rd_reg(2'd0, STAT);
        chk("status_7", r_data, 32'h7);
        wr_reg(2'd0, STAT, 32'h4);
        tick(2);
        chk("irq_w1c", 32'(irq), 32'h0);

        // CLEAR pulse
        wr_reg(2'd2, CTRL, 32'h3);
        tick(1);
        set_full(2, 1'b1);
        tick(2);
        rd_reg(2'd2, STAT);
        wr_reg(2'd2, CLR, 32'h0);
        chk("clr_before", 32'(sctrl_clear), 32'h0);
        tick(1);
        chk("clr_pulse", 32'(sctrl_clear), 32'h4);
        tick(1);
        chk("clr_after", 32'(sctrl_clear), 32'h0);
        rd_reg(2'd2, STAT);
        chk("clr_pend", r_data, 32'h3);

        // error paths, back-to-back
        err_xfer(2'd0, CTRL, 1'b1, 3'b010, 4'b0010);
        err_xfer(2'd0, CTRL, 1'b0, 3'b000, MID);
        err_xfer(2'd1, BUF, 1'b1, 3'b010, MID);
        rd_reg(2'd0, CTRL);
        chk("err_ctrl_kept", r_data, 32'h3);

        // W1C colliding with a new full edge
        set_full(0, 1'b0);
        tick(1);
        set_full(0, 1'b1);
        tick(1);
        set_full(0, 1'b0);
        tick(1);
        wr_reg(2'd0, STAT, 32'h4);
        set_full(0, 1'b1);
        tick(1);
        rd_reg(2'd0, STAT);
        chk("set_wins", r_data, 32'h7);

        // reset during RWAIT
        sctrl_full = '0;
        tick(2);
        HSEL = 1; HTRANS = 2'b10; HADDR = BASE | 32'h4; HWRITE = 0; HSIZE = 3'b010; HMASTER = MID;
        tick(1);
        HSEL = 0; HTRANS = 2'b00;
        chk("rst_raddr_rdy", 32'(HREADY), 32'h0);
        tick(1);
        chk("rst_rwait_rdy", 32'(HREADY), 32'h0);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_rdy", 32'(HREADY), 32'h1);
        chk("rst_mid_en", 32'(sctrl_en), 32'h0);
        chk("rst_mid_irq", 32'(irq), 32'h0);
        chk("rst_mid_resp", 32'(HRESP), 32'h0);
        rst = 1'b0;
        m_ch_en = '0; m_irq_en = '0; m_pend = '0;
        rd_reg(2'd0, CTRL);
        chk("rst_ctrl0", r_data, 32'h0);

        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 11);
            ch = 2'($urandom_range(0, NUM_CH - 1));
            case (op)
                0, 1, 2: begin new_out(); rd_buf(ch, 6'($urandom)); end
                3: rd_reg(ch, 2'($urandom_range(1, 3)));
                4: wr_reg(ch, CTRL, $urandom);
                5: wr_reg(ch, STAT, $urandom);
                6: begin
                    wr_reg(ch, CLR, $urandom);
                    tick(1);
                    chk("rnd_clr", 32'(sctrl_clear), 32'(1) << ch);
                end
                7: begin
                    mst = 4'($urandom);
                    if (mst == MID) mst = 4'b0010;
                    err_xfer(ch, 2'($urandom), 1'($urandom), 3'b010, mst);
                end
                8: begin
                    sz = 3'($urandom);
                    if (sz == 3'b010) sz = 3'b000;
                    err_xfer(ch, 2'($urandom), 1'($urandom), sz, MID);
                end
                9: err_xfer(ch, BUF, 1'b1, 3'b010, MID);
                default: begin
                    tick(1);
                    c = $urandom_range(0, NUM_CH - 1);
                    set_full(c, !sctrl_full[c]);
                    tick(2);
                    chk("rnd_irq", 32'(irq), 32'(|m_pend));
                end
            endcase
            if ($urandom_range(0, 2) == 0) tick(1);
        end
        tick(2);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
